// File: rtl/tms9995_pkg.sv
// Shared types and constants for the TMS9995 interrupt scheduler.
// Source index order everywhere is {INT4, INT3, INT1} = bits {2, 1, 0}.
package tms9995_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_PRESENT = 2'd1,
        IC_HOLD    = 2'd2
    } ic_state_e;

    localparam logic [3:0] LVL_INT1 = 4'd1;
    localparam logic [3:0] LVL_INT3 = 4'd3;
    localparam logic [3:0] LVL_INT4 = 4'd4;
    localparam logic [3:0] LVL_NONE = 4'hF;

    localparam logic [3:0] BST_VECFETCH = 4'b0101;

    localparam int SRC_INT1 = 0;
    localparam int SRC_INT3 = 1;
    localparam int SRC_INT4 = 2;
    localparam int NUM_SRC  = 3;

    localparam int CRU_EN_LSB   = 0;
    localparam int CRU_MODE_LSB = 4;
    localparam int CRU_PEND_LSB = 8;
    localparam int CRU_ACK_LSB  = 12;

    function automatic logic [3:0] highest_level(input logic [NUM_SRC-1:0] act);
        logic [3:0] lvl;
        lvl = LVL_NONE;
        if (act[SRC_INT4]) lvl = LVL_INT4;
        if (act[SRC_INT3]) lvl = LVL_INT3;
        if (act[SRC_INT1]) lvl = LVL_INT1;
        return lvl;
    endfunction

endpackage

// File: rtl/tms9995_int_ctrl_if.sv
// CPU-side bus, CRU port and interrupt source/request signals of the scheduler.
interface tms9995_int_ctrl_if;
    logic [15:0] ab;
    logic [3:0]  bst;
    logic        cruclk;
    logic        cruout;
    logic        cruin;
    logic        int1_src;
    logic        int3_src;
    logic        int4_src;
    logic        irq;
    logic [3:0]  ic;

    modport master (
        output ab, bst, cruclk, cruout, int1_src, int3_src, int4_src,
        input  cruin, irq, ic
    );

    modport slave (
        input  ab, bst, cruclk, cruout, int1_src, int3_src, int4_src,
        output cruin, irq, ic
    );
endinterface

// File: rtl/int_src_latch.sv
// One interrupt source: 2-flop synchronizer, edge/level qualification, pending latch.
// Pending is set 3 clocks after the raw rising edge; a same-cycle set beats clear.
module int_src_latch (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic clr,
    output logic pending,
    output logic sync
);
    logic [2:0] sync_q, sync_d;
    logic       pend_q, pend_d;
    logic       set;

    always_comb begin
        sync_d = {sync_q[1:0], src};
        // stage 3 only exists to give the edge detector a previous value
        set    = edge_mode ? (sync_q[1] & ~sync_q[2]) : sync_q[1];
        pend_d = set | (pend_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
    assign sync    = sync_q[1];
endmodule

// File: rtl/tms9995_int_ctrl.sv
// TMS9995 interrupt scheduler: CRU control register, per-source latches, priority, ack hold-off.
// irq/ic registered, 4 clocks from raw source edge; no backpressure, acks are single-cycle events.
module tms9995_int_ctrl
    import tms9995_pkg::*;
#(
    parameter logic [15:0] CRU_BASE = 16'h1F00,
    parameter int          HOLDOFF  = 4
) (
    input logic               clk,
    input logic               rst,
    tms9995_int_ctrl_if.slave bus
);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

    logic [NUM_SRC-1:0] en_q, en_d, mode_q, mode_d;
    logic [NUM_SRC-1:0] pend_clr_cru, ack_hit, clr, pending, act, src_vec, sync_unused;
    logic [3:0]         ack_cnt_q, ack_cnt_d, hold_q, hold_d, ic_q, ic_d, cru_bit, ack_lvl;
    logic               vf_q, vf_d, irq_q, irq_d, cru_wr, ack_evt, ack_any;
    logic [15:0]        cru_rd_vec;
    ic_state_e          state_q, state_d;

    assign cru_bit = bus.ab[4:1];
    assign cru_wr  = (bus.ab[15:5] == CRU_BASE[15:5]) & ~bus.cruclk;
    assign ack_lvl = bus.ab[5:2];
    assign src_vec = {bus.int4_src, bus.int3_src, bus.int1_src};

    always_comb begin
        en_d         = en_q;
        mode_d       = mode_q;
        pend_clr_cru = '0;
        if (cru_wr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cru_bit == 4'(CRU_EN_LSB + i))   en_d[i]         = bus.cruout;
                if (cru_bit == 4'(CRU_MODE_LSB + i)) mode_d[i]       = bus.cruout;
                if (cru_bit == 4'(CRU_PEND_LSB + i)) pend_clr_cru[i] = ~bus.cruout;
            end
        end
    end

    // Count one acknowledge per vector fetch, however long bst dwells on it.
    always_comb begin
        vf_d              = (bus.bst == BST_VECFETCH);
        ack_evt           = vf_d & ~vf_q;
        ack_hit[SRC_INT1] = ack_evt & (ack_lvl == LVL_INT1);
        ack_hit[SRC_INT3] = ack_evt & (ack_lvl == LVL_INT3);
        ack_hit[SRC_INT4] = ack_evt & (ack_lvl == LVL_INT4);
        ack_any           = |ack_hit;
        ack_cnt_d         = ack_cnt_q + 4'(ack_any);
        clr               = ack_hit | pend_clr_cru;
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        int_src_latch u_latch (
            .clk       (clk),
            .rst       (rst),
            .src       (src_vec[g]),
            .edge_mode (mode_q[g]),
            .clr       (clr[g]),
            .pending   (pending[g]),
            .sync      (sync_unused[g])
        );
    end

    assign act = pending & en_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IC_IDLE: begin
                if (|act) state_d = IC_PRESENT;
            end
            IC_PRESENT: begin
                if (ack_any) begin
                    state_d = IC_HOLD;
                    hold_d  = HOLD_LOAD;
                end else if (~|act) begin
                    state_d = IC_IDLE;
                end
            end
            IC_HOLD: begin
                if (hold_q == 4'd0) state_d = IC_IDLE;
                else                hold_d  = hold_q - 4'd1;
            end
            default: state_d = IC_IDLE;
        endcase
        irq_d = (state_d == IC_PRESENT);
        ic_d  = (state_d == IC_PRESENT) ? highest_level(act) : LVL_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IC_IDLE;
            hold_q    <= '0;
            irq_q     <= 1'b0;
            ic_q      <= LVL_NONE;
            en_q      <= '0;
            mode_q    <= '0;
            ack_cnt_q <= '0;
            vf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            irq_q     <= irq_d;
            ic_q      <= ic_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            ack_cnt_q <= ack_cnt_d;
            vf_q      <= vf_d;
        end
    end

    always_comb begin
        cru_rd_vec                       = '0;
        cru_rd_vec[CRU_EN_LSB +: 3]      = en_q;
        cru_rd_vec[CRU_MODE_LSB +: 3]    = mode_q;
        cru_rd_vec[CRU_PEND_LSB +: 3]    = pending;
        cru_rd_vec[CRU_ACK_LSB +: 4]     = ack_cnt_q;
    end

    assign bus.cruin = cru_rd_vec[cru_bit];
    assign bus.irq   = irq_q;
    assign bus.ic    = ic_q;
endmodule

// File: tb/tb_tms9995_int_ctrl.sv
// Directed bench for the interrupt scheduler: latency, priority, hold-off, CRU map, async reset.
module tb_tms9995_int_ctrl;
    localparam logic [15:0] CRU_BASE = 16'h1F00;
    localparam int          HOLDOFF  = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errs   = 0;
    logic v;
    logic [3:0] cnt;

    tms9995_int_ctrl_if bus ();

    tms9995_int_ctrl #(.CRU_BASE(CRU_BASE), .HOLDOFF(HOLDOFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cru_wr(input int b, input logic val);
        bus.ab     = CRU_BASE | 16'(b << 1);
        bus.cruout = val;
        bus.cruclk = 1'b0;
        tick();
        bus.cruclk = 1'b1;
        bus.ab     = 16'h0000;
    endtask

    task automatic cru_rd(input int b, output logic val);
        bus.ab = CRU_BASE | 16'(b << 1);
        #1;
        val = bus.cruin;
    endtask

    task automatic rd_cnt(output logic [3:0] c);
        logic t;
        for (int i = 0; i < 4; i++) begin
            cru_rd(12 + i, t);
            c[i] = t;
        end
    endtask

    task automatic ack(input int lvl);
        bus.ab  = 16'(lvl << 2);
        bus.bst = 4'b0101;
        tick();
        bus.bst = 4'b0000;
    endtask

    initial begin
        rst          = 1'b1;
        bus.ab       = 16'h0000;
        bus.bst      = 4'b0000;
        bus.cruclk   = 1'b1;
        bus.cruout   = 1'b0;
        bus.int1_src = 1'b0;
        bus.int3_src = 1'b0;
        bus.int4_src = 1'b0;
        tick();
        tick();
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_ic", bus.ic, 4'hF);
        rst = 1'b0;
        tick();

        // INT4 edge mode, single-cycle pulse
        cru_wr(2, 1'b1);
        cru_wr(6, 1'b1);
        bus.int4_src = 1'b1;
        tick();
        bus.int4_src = 1'b0;
        tick();
        tick();
        chk("int4_lat3_irq", bus.irq, 1'b0);
        tick();
        chk("int4_lat4_irq", bus.irq, 1'b1);
        chk("int4_lat4_ic", bus.ic, 4'd4);
        cru_rd(10, v);
        chk("int4_pend_set", v, 1'b1);
        ack(4);
        for (int i = 0; i < HOLDOFF; i++) begin
            chk("int4_holdoff_irq", bus.irq, 1'b0);
            if (i < HOLDOFF - 1) tick();
        end
        cru_rd(10, v);
        chk("int4_pend_clr", v, 1'b0);
        rd_cnt(cnt);
        chk("ackcnt_1", cnt, 4'd1);
        tick();

        // INT1 (level) and INT4 together, INT1 wins, INT4 follows after hold-off
        cru_wr(0, 1'b1);
        bus.int1_src = 1'b1;
        bus.int4_src = 1'b1;
        tick();
        bus.int1_src = 1'b0;
        bus.int4_src = 1'b0;
        tick();
        tick();
        tick();
        chk("prio_irq", bus.irq, 1'b1);
        chk("prio_ic1", bus.ic, 4'd1);
        ack(1);
        chk("prio_ack_ic", bus.ic, 4'hF);
        for (int i = 0; i < HOLDOFF; i++) tick();
        chk("prio_idle_irq", bus.irq, 1'b0);
        tick();
        chk("prio_next_irq", bus.irq, 1'b1);
        chk("prio_next_ic4", bus.ic, 4'd4);
        ack(4);
        for (int i = 0; i < HOLDOFF + 2; i++) tick();
        chk("prio_done_irq", bus.irq, 1'b0);

        // INT3 level mode, source held high across the acknowledge
        cru_wr(1, 1'b1);
        bus.int3_src = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("lvl_irq", bus.irq, 1'b1);
        chk("lvl_ic3", bus.ic, 4'd3);
        ack(3);
        chk("lvl_ack_irq", bus.irq, 1'b0);
        for (int i = 0; i < HOLDOFF; i++) begin
            tick();
            chk("lvl_hold_irq", bus.irq, 1'b0);
        end
        tick();
        chk("lvl_reassert_irq", bus.irq, 1'b1);
        chk("lvl_reassert_ic", bus.ic, 4'd3);
        cru_rd(9, v);
        chk("lvl_pend_resets", v, 1'b1);
        bus.int3_src = 1'b0;
        tick();
        tick();
        tick();
        chk("lvl_sticky_irq", bus.irq, 1'b1);
        cru_wr(9, 1'b0);
        chk("lvl_clr_same_irq", bus.irq, 1'b1);
        tick();
        chk("lvl_clr_next_irq", bus.irq, 1'b0);
        chk("lvl_clr_next_ic", bus.ic, 4'hF);

        // INT1 pending while disabled, then enable, then CRU clear
        cru_wr(0, 1'b0);
        bus.int1_src = 1'b1;
        tick();
        bus.int1_src = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("dis_irq", bus.irq, 1'b0);
        cru_rd(8, v);
        chk("dis_pend", v, 1'b1);
        cru_wr(0, 1'b1);
        chk("en_same_irq", bus.irq, 1'b0);
        tick();
        chk("en_next_irq", bus.irq, 1'b1);
        chk("en_next_ic", bus.ic, 4'd1);
        cru_wr(8, 1'b0);
        tick();
        chk("crucl_irq", bus.irq, 1'b0);
        chk("crucl_ic", bus.ic, 4'hF);

        // Ack counter: dwelling on vector fetch counts once, then wrap at 16
        rd_cnt(cnt);
        chk("ackcnt_4", cnt, 4'd4);
        bus.ab  = 16'(4 << 2);
        bus.bst = 4'b0101;
        tick();
        tick();
        tick();
        bus.bst = 4'b0000;
        tick();
        rd_cnt(cnt);
        chk("ackcnt_dwell", cnt, 4'd5);
        for (int i = 0; i < 11; i++) begin
            ack(4);
            tick();
        end
        rd_cnt(cnt);
        chk("ackcnt_wrap", cnt, 4'd0);
        cru_wr(7, 1'b1);
        cru_rd(7, v);
        chk("bit7_reads0", v, 1'b0);
        cru_rd(3, v);
        chk("bit3_reads0", v, 1'b0);
        cru_rd(6, v);
        chk("mode4_reads1", v, 1'b1);

        // Asynchronous reset while presenting
        bus.int4_src = 1'b1;
        tick();
        bus.int4_src = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_irq", bus.irq, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq", bus.irq, 1'b0);
        chk("arst_ic", bus.ic, 4'hF);
        cru_rd(0, v);
        chk("arst_en1", v, 1'b0);
        cru_rd(6, v);
        chk("arst_mode4", v, 1'b0);
        cru_rd(10, v);
        chk("arst_pend4", v, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_irq", bus.irq, 1'b0);
        rd_cnt(cnt);
        chk("post_rst_cnt", cnt, 4'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
